// File: rtl/max7219_pkg.sv
// Shared definitions for the MAX7219 serial receiver: register map, FSM states
// and the decoded register-file record.
package max7219_pkg;

  localparam logic [3:0] ADDR_NOOP         = 4'h0;
  localparam logic [3:0] ADDR_DIGIT0       = 4'h1;
  localparam logic [3:0] ADDR_DIGIT1       = 4'h2;
  localparam logic [3:0] ADDR_DIGIT2       = 4'h3;
  localparam logic [3:0] ADDR_DIGIT3       = 4'h4;
  localparam logic [3:0] ADDR_DIGIT4       = 4'h5;
  localparam logic [3:0] ADDR_DIGIT5       = 4'h6;
  localparam logic [3:0] ADDR_DIGIT6       = 4'h7;
  localparam logic [3:0] ADDR_DIGIT7       = 4'h8;
  localparam logic [3:0] ADDR_DECODE_MODE  = 4'h9;
  localparam logic [3:0] ADDR_INTENSITY    = 4'hA;
  localparam logic [3:0] ADDR_SCAN_LIMIT   = 4'hB;
  localparam logic [3:0] ADDR_SHUTDOWN     = 4'hC;
  localparam logic [3:0] ADDR_RSVD_D       = 4'hD;
  localparam logic [3:0] ADDR_RSVD_E       = 4'hE;
  localparam logic [3:0] ADDR_DISPLAY_TEST = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } rx_state_e;

  typedef struct packed {
    logic [7:0][7:0] digit;
    logic [7:0]      decode_mode;
    logic [3:0]      intensity;
    logic [2:0]      scan_limit;
    logic            shutdown_n;
    logic            display_test;
  } max7219_regs_t;

  // A frame is good only when a whole number (>0) of 16-bit words was clocked in.
  function automatic logic count_ok(input logic [4:0] cnt);
    return cnt[4] && (cnt[3:0] == 4'd0);
  endfunction

endpackage

// File: rtl/max7219_rx_sync.sv
// Multi-flop synchronizer for one asynchronous pin plus a trailing flop
// that yields single-cycle rising/falling edge strobes.
module max7219_rx_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign sync_o = sync_q[STAGES-1];
  assign rise_o = sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/max7219_rx.sv
// MAX7219-compatible serial slave: oversamples CLK/DIN/LOAD in the system clock
// domain, latches 16-bit frames on LOAD rising and decodes them into registers.
module max7219_rx
  import max7219_pkg::*;
#(
  parameter int G_SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_max7219_clk,
  input  logic       i_max7219_din,
  input  logic       i_max7219_load,
  output logic       o_max7219_dout,
  output logic       o_frame_valid,
  output logic       o_frame_err,
  output logic [3:0] o_addr,
  output logic [7:0] o_data,
  input  logic [2:0] i_rd_digit,
  output logic [7:0] o_rd_data,
  output logic [7:0] o_decode_mode,
  output logic [3:0] o_intensity,
  output logic [2:0] o_scan_limit,
  output logic       o_shutdown_n,
  output logic       o_display_test
);

  logic clk_sync, clk_rise, clk_fall;
  logic din_sync, din_rise, din_fall;
  logic load_sync, load_rise, load_fall;

  max7219_rx_sync #(.STAGES(G_SYNC_STAGES), .RST_VAL(1'b0)) u_sync_clk (
    .clk(clk), .rst_n(rst_n), .async_i(i_max7219_clk),
    .sync_o(clk_sync), .rise_o(clk_rise), .fall_o(clk_fall)
  );

  max7219_rx_sync #(.STAGES(G_SYNC_STAGES), .RST_VAL(1'b0)) u_sync_din (
    .clk(clk), .rst_n(rst_n), .async_i(i_max7219_din),
    .sync_o(din_sync), .rise_o(din_rise), .fall_o(din_fall)
  );

  // LOAD idles high; resetting its chain high avoids a phantom frame at reset release.
  max7219_rx_sync #(.STAGES(G_SYNC_STAGES), .RST_VAL(1'b1)) u_sync_load (
    .clk(clk), .rst_n(rst_n), .async_i(i_max7219_load),
    .sync_o(load_sync), .rise_o(load_rise), .fall_o(load_fall)
  );

  rx_state_e     state_q, state_d;
  logic [15:0]   sr_q, sr_d;
  logic [4:0]    cnt_q, cnt_d;
  max7219_regs_t regs_q, regs_d;
  logic [3:0]    addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic [7:0]    rd_q;
  logic [2:0]    dig_idx;

  assign dig_idx = 3'(sr_q[11:8] - 4'd1);

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    regs_d  = regs_q;
    addr_d  = addr_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;

    if (clk_rise) begin
      sr_d  = {sr_q[14:0], din_sync};
      cnt_d = {cnt_q[4] | (&cnt_q[3:0]), cnt_q[3:0] + 4'd1};
    end

    case (state_q)
      ST_IDLE: begin
        if (load_fall)      state_d = ST_SHIFT;
        else if (load_rise) state_d = ST_LATCH;
      end
      ST_SHIFT: begin
        if (load_rise) state_d = ST_LATCH;
      end
      ST_LATCH: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        if (count_ok(cnt_q)) begin
          valid_d = 1'b1;
          addr_d  = sr_q[11:8];
          data_d  = sr_q[7:0];
          case (sr_q[11:8])
            ADDR_DIGIT0, ADDR_DIGIT1, ADDR_DIGIT2, ADDR_DIGIT3,
            ADDR_DIGIT4, ADDR_DIGIT5, ADDR_DIGIT6, ADDR_DIGIT7:
                               regs_d.digit[dig_idx] = sr_q[7:0];
            ADDR_DECODE_MODE:  regs_d.decode_mode    = sr_q[7:0];
            ADDR_INTENSITY:    regs_d.intensity      = sr_q[3:0];
            ADDR_SCAN_LIMIT:   regs_d.scan_limit     = sr_q[2:0];
            ADDR_SHUTDOWN:     regs_d.shutdown_n     = sr_q[0];
            ADDR_DISPLAY_TEST: regs_d.display_test   = sr_q[0];
            ADDR_NOOP, ADDR_RSVD_D, ADDR_RSVD_E: ;
            default: ;
          endcase
        end else begin
          err_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      regs_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      regs_q  <= regs_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      rd_q    <= regs_q.digit[i_rd_digit];
    end
  end

  assign o_max7219_dout = sr_q[15];
  assign o_frame_valid  = valid_q;
  assign o_frame_err    = err_q;
  assign o_addr         = addr_q;
  assign o_data         = data_q;
  assign o_rd_data      = rd_q;
  assign o_decode_mode  = regs_q.decode_mode;
  assign o_intensity    = regs_q.intensity;
  assign o_scan_limit   = regs_q.scan_limit;
  assign o_shutdown_n   = regs_q.shutdown_n;
  assign o_display_test = regs_q.display_test;

  logic unused_sig;
  assign unused_sig = ^{clk_sync, clk_fall, din_rise, din_fall, load_sync, sr_q[14:12]};

endmodule

// File: doc/max7219_rx.md
MAX7219_RX -- requirements
Module: max7219_rx

Interface
REQ-001 G_SYNC_STAGES, 2, number of synchronizer flip-flops on each MAX7219 pin input (range 2..4) SHALL be a generic.
REQ-002 clk  in  1  system clock; single clock domain; all outputs are registered on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assertion, active-low.
REQ-004 i_max7219_clk  in  1  serial clock from a MAX7219 transmitter; asynchronous to clk.
REQ-005 i_max7219_din  in  1  serial data, MSB first.
REQ-006 i_max7219_load  in  1  load/CS; frame latched on its rising edge.
REQ-007 o_max7219_dout  out  1  daisy-chain output = bit 15 of the shift register.
REQ-008 o_frame_valid  out  1  one-cycle pulse when a frame is latched.
REQ-009 o_frame_err  out  1  one-cycle pulse when a latched frame has a bit count not a non-zero multiple of 16.
REQ-010 o_addr / o_data  out  4 / 8  address D11..D8 and data D7..D0 of the last valid frame.
REQ-011 i_rd_digit  in  3  digit register select (0 = digit 0 at address 0x1).
REQ-012 o_rd_data  out  8  content of the selected digit register, registered, 1-cycle latency.
REQ-013 o_decode_mode  out  8  decode-mode register (address 0x9).
REQ-014 o_intensity  out  4  intensity register, data bits 3..0 (address 0xA).
REQ-015 o_scan_limit  out  3  scan-limit register, data bits 2..0 (address 0xB).
REQ-016 o_shutdown_n  out  1  shutdown register, data bit 0 (address 0xC); 0 = shutdown.
REQ-017 o_display_test  out  1  display-test register, data bit 0 (address 0xF).

Function
REQ-018 Each pin input SHALL pass through G_SYNC_STAGES flip-flops, followed by one extra flop for edge detection.
REQ-019 On a detected rising edge of synchronized i_max7219_clk, the 16-bit shift register SHALL shift left with din in bit 0, regardless of load level.
REQ-020 Bit counter: 5 bits; +1 per shift; wraps 31->16 (bit 4 sticky once set); cleared in LATCH.
REQ-021 FSM states: IDLE (load high, waiting), SHIFT (load low), LATCH (one cycle); IDLE->SHIFT on load falling edge; SHIFT->LATCH on load rising edge; LATCH->IDLE unconditionally.
REQ-022 A load rising edge seen in IDLE (no falling edge before it) SHALL still enter LATCH.
REQ-023 If a clk rising edge and a load rising edge are detected in the same cycle, the shift SHALL happen first and the latched word SHALL include that bit.
REQ-024 In LATCH with a valid count (bit 4 set, bits 3..0 = 0): register write per address, o_addr/o_data updated, o_frame_valid = 1.
REQ-025 In LATCH with an invalid count: no register write, o_addr/o_data unchanged, o_frame_err = 1, o_frame_valid = 0.
REQ-026 Address 0x0 (no-op) and addresses 0xD, 0xE SHALL pulse o_frame_valid without writing any register; bits D15..D12 are ignored.
REQ-027 Latency: o_frame_valid/o_frame_err SHALL assert exactly G_SYNC_STAGES+2 clk edges after the first clk edge that samples load high.
REQ-028 For daisy-chained devices, only the last 16 bits shifted before the load edge SHALL be decoded; o_max7219_dout SHALL equal din delayed by 16 serial clocks.

Reset
REQ-029 On rst_n low: FSM = IDLE; shift register, counter, all digit registers and all configuration registers = 0; o_shutdown_n = 0; all pulses = 0; o_max7219_dout = 0.
REQ-030 Reset asserted mid-frame SHALL discard the partial frame; after release, the first load rising edge with fewer than 16 bits SHALL produce o_frame_err.

Structure
REQ-031 Package max7219_pkg SHALL hold the register address constants (0x0..0xF), the FSM state enum and the register-file record typedef.
REQ-032 Sub-module max7219_rx_sync SHALL implement one synchronizer plus rising/falling edge detector, instantiated three times.

Verification
REQ-033 Send 0x0A05 with 16 clocks, then load rises -> o_intensity = 0x5; o_frame_valid pulses once; o_addr = 0xA; o_data = 0x05.
REQ-034 Send 0x0C01, then 0x0F01, then 0x0F00 -> o_shutdown_n = 1; o_display_test goes 1 then 0.
REQ-035 Send 0x0155 ... 0x08AA to digits 0..7, then sweep i_rd_digit 0..7 -> o_rd_data = 0x55 ... 0xAA, each 1 cycle after its select.
REQ-036 Send 12 bits then load rises -> o_frame_err pulses; all registers unchanged.
REQ-037 Send 32 bits 0x0B07_0A03 in one load-low window -> only 0x0A03 is decoded (o_intensity = 3; o_scan_limit unchanged); o_max7219_dout reproduces 0x0B07.
REQ-038 Assert rst_n low after 8 bits of 0x0B07, then send a full 0x0B07 -> o_scan_limit = 7; no residue from the aborted frame.
